// File: rtl/systolic_array_2by2.sv
`default_nettype none
// ============================================================================
// Module  : systolic_array_2by2
// Brief   : 2x2 systolic MAC array computing a valid-mode 3x3 cross-correlation
//           of a latched 4x4 8-bit tile, results modulo 256.
// Revision: 1.0 - initial release
// ============================================================================
module systolic_array_2by2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mat_input11, mat_input12, mat_input13, mat_input14,
    input  logic [7:0] mat_input21, mat_input22, mat_input23, mat_input24,
    input  logic [7:0] mat_input31, mat_input32, mat_input33, mat_input34,
    input  logic [7:0] mat_input41, mat_input42, mat_input43, mat_input44,
    input  logic [7:0] filter11, filter12, filter13,
    input  logic [7:0] filter21, filter22, filter23,
    input  logic [7:0] filter31, filter32, filter33,
    output logic       done_2_2,
    output logic [7:0] result11,
    output logic [7:0] result12,
    output logic [7:0] result21,
    output logic [7:0] result22
);

    localparam logic [3:0] c_NUM_TAPS  = 4'd9;
    localparam logic [3:0] c_LAST_STEP = 4'd11;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state, w_next_state;

    logic [7:0] w_img [16];
    logic [7:0] w_flt [9];
    logic [7:0] r_img [16];
    logic [7:0] r_flt [9];
    logic [3:0] r_step;

    logic [1:0] w_m, w_n;
    logic [3:0] w_base;
    logic       w_issue;
    logic [7:0] w_tap, w_px11, w_px12, w_px21, w_px22;

    // Skew stage 1 feeds PE12/PE21; stage 2 feeds PE22
    logic       r_v1, r_v2;
    logic [7:0] r_tap1, r_px12, r_px21, r_px22_d1;
    logic [7:0] r_tap2, r_px22;
    logic [7:0] r_acc11, r_acc12, r_acc21, r_acc22;

    assign w_img = '{mat_input11, mat_input12, mat_input13, mat_input14,
                     mat_input21, mat_input22, mat_input23, mat_input24,
                     mat_input31, mat_input32, mat_input33, mat_input34,
                     mat_input41, mat_input42, mat_input43, mat_input44};
    assign w_flt = '{filter11, filter12, filter13,
                     filter21, filter22, filter23,
                     filter31, filter32, filter33};

    // Tap index k = 3*m + n maps to tile offset 4*m + n for the top-left PE
    always_comb begin
        w_m = 2'd0;
        w_n = 2'd0;
        case (r_step)
            4'd0: begin w_m = 2'd0; w_n = 2'd0; end
            4'd1: begin w_m = 2'd0; w_n = 2'd1; end
            4'd2: begin w_m = 2'd0; w_n = 2'd2; end
            4'd3: begin w_m = 2'd1; w_n = 2'd0; end
            4'd4: begin w_m = 2'd1; w_n = 2'd1; end
            4'd5: begin w_m = 2'd1; w_n = 2'd2; end
            4'd6: begin w_m = 2'd2; w_n = 2'd0; end
            4'd7: begin w_m = 2'd2; w_n = 2'd1; end
            4'd8: begin w_m = 2'd2; w_n = 2'd2; end
            default: begin w_m = 2'd0; w_n = 2'd0; end
        endcase
    end

    assign w_base  = {w_m, w_n};
    assign w_issue = (r_state == ST_RUN) && (r_step < c_NUM_TAPS);
    assign w_tap   = w_issue ? r_flt[r_step] : 8'd0;
    assign w_px11  = r_img[w_base];
    assign w_px12  = r_img[w_base + 4'd1];
    assign w_px21  = r_img[w_base + 4'd4];
    assign w_px22  = r_img[w_base + 4'd5];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: w_next_state = ST_RUN;
            ST_RUN:  if (r_step == c_LAST_STEP) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_DONE;
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_img     <= '{default: 8'd0};
            r_flt     <= '{default: 8'd0};
            r_step    <= 4'd0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_tap1    <= 8'd0;
            r_px12    <= 8'd0;
            r_px21    <= 8'd0;
            r_px22_d1 <= 8'd0;
            r_tap2    <= 8'd0;
            r_px22    <= 8'd0;
            r_acc11   <= 8'd0;
            r_acc12   <= 8'd0;
            r_acc21   <= 8'd0;
            r_acc22   <= 8'd0;
            done_2_2  <= 1'b0;
            result11  <= 8'd0;
            result12  <= 8'd0;
            result21  <= 8'd0;
            result22  <= 8'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_img   <= w_img;
                    r_flt   <= w_flt;
                    r_step  <= 4'd0;
                    r_v1    <= 1'b0;
                    r_v2    <= 1'b0;
                    r_acc11 <= 8'd0;
                    r_acc12 <= 8'd0;
                    r_acc21 <= 8'd0;
                    r_acc22 <= 8'd0;
                end
                ST_RUN: begin
                    r_step    <= r_step + 4'd1;
                    r_v1      <= w_issue;
                    r_tap1    <= w_tap;
                    r_px12    <= w_px12;
                    r_px21    <= w_px21;
                    r_px22_d1 <= w_px22;
                    r_v2      <= r_v1;
                    r_tap2    <= r_tap1;
                    r_px22    <= r_px22_d1;
                    if (w_issue) r_acc11 <= r_acc11 + w_tap * w_px11;
                    if (r_v1) begin
                        r_acc12 <= r_acc12 + r_tap1 * r_px12;
                        r_acc21 <= r_acc21 + r_tap1 * r_px21;
                    end
                    if (r_v2) r_acc22 <= r_acc22 + r_tap2 * r_px22;
                    // PE22 finished its last MAC on the previous edge
                    if (r_step == c_LAST_STEP) begin
                        result11 <= r_acc11;
                        result12 <= r_acc12;
                        result21 <= r_acc21;
                        result22 <= r_acc22;
                        done_2_2 <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_2by2.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_array_2by2
// Brief   : Self-checking bench comparing the array against a direct
//           cross-correlation model over directed and random tiles.
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_array_2by2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] img [16];
    logic [7:0] flt [9];
    logic       done_2_2;
    logic [7:0] result11, result12, result21, result22;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_array_2by2 dut (
        .clk(clk), .rst(rst),
        .mat_input11(img[0]),  .mat_input12(img[1]),  .mat_input13(img[2]),  .mat_input14(img[3]),
        .mat_input21(img[4]),  .mat_input22(img[5]),  .mat_input23(img[6]),  .mat_input24(img[7]),
        .mat_input31(img[8]),  .mat_input32(img[9]),  .mat_input33(img[10]), .mat_input34(img[11]),
        .mat_input41(img[12]), .mat_input42(img[13]), .mat_input43(img[14]), .mat_input44(img[15]),
        .filter11(flt[0]), .filter12(flt[1]), .filter13(flt[2]),
        .filter21(flt[3]), .filter22(flt[4]), .filter23(flt[5]),
        .filter31(flt[6]), .filter32(flt[7]), .filter33(flt[8]),
        .done_2_2(done_2_2),
        .result11(result11), .result12(result12),
        .result21(result21), .result22(result22)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: exact integer correlation sum, reduced modulo 256
    function automatic logic [7:0] model(input int i, input int j);
        int s = 0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                s += int'(img[(i + m) * 4 + (j + n)]) * int'(flt[m * 3 + n]);
        return 8'(s % 256);
    endfunction

    function automatic logic [32:0] outs();
        return {done_2_2, result11, result12, result21, result22};
    endfunction

    task automatic set_zero();
        for (int k = 0; k < 16; k++) img[k] = 8'd0;
        for (int k = 0; k < 9; k++) flt[k] = 8'd0;
    endtask

    task automatic set_random();
        for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
        for (int k = 0; k < 9; k++) flt[k] = 8'($urandom);
    endtask

    task automatic set_nominal();
        logic [7:0] ti [16];
        logic [7:0] tf [9];
        ti = '{8'd2, 8'd1, 8'd3, 8'd1, 8'd0, 8'd2, 8'd4, 8'd2,
               8'd1, 8'd3, 8'd2, 8'd0, 8'd2, 8'd1, 8'd0, 8'd1};
        tf = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
        img = ti;
        flt = tf;
    endtask

    task automatic set_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r * 4 + c] = 8'(10 * (r + 1) + (c + 1));
        for (int k = 0; k < 9; k++) flt[k] = 8'd0;
        flt[4] = 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_outs", 64'(outs()), 64'd0);
        rst = 1'b0;
    endtask

    // rst is low and inputs set; next rising edge is E1
    task automatic run_seq(input string tag, input bit zero_at_e3,
                           input logic [7:0] e11, input logic [7:0] e12,
                           input logic [7:0] e21, input logic [7:0] e22);
        for (int e = 1; e <= 13; e++) begin
            @(posedge clk); #1;
            if (zero_at_e3 && e == 3) set_zero();
            if (e < 13) chk({tag, "_pre"}, 64'(outs()), 64'd0);
        end
        chk({tag, "_done"}, 64'(done_2_2), 64'd1);
        chk({tag, "_r11"}, 64'(result11), 64'(e11));
        chk({tag, "_r12"}, 64'(result12), 64'(e12));
        chk({tag, "_r21"}, 64'(result21), 64'(e21));
        chk({tag, "_r22"}, 64'(result22), 64'(e22));
        set_random();
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold"}, 64'(outs()), {31'd0, 1'b1, e11, e12, e21, e22});
    endtask

    task automatic run_model(input string tag, input bit zero_at_e3);
        logic [7:0] a, b, c, d;
        a = model(0, 0); b = model(0, 1); c = model(1, 0); d = model(1, 1);
        run_seq(tag, zero_at_e3, a, b, c, d);
    endtask

    initial begin
        set_random();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("reset_hold", 64'(outs()), 64'd0);
            set_random();
        end

        do_reset(); set_nominal();
        run_seq("nominal", 1'b0, 8'd12, 8'd10, 8'd9, 8'd10);

        do_reset();
        for (int k = 0; k < 16; k++) img[k] = 8'd255;
        for (int k = 0; k < 9; k++) flt[k] = 8'd255;
        run_seq("wrap", 1'b0, 8'd9, 8'd9, 8'd9, 8'd9);

        do_reset(); set_identity();
        run_seq("identity", 1'b0, 8'd22, 8'd23, 8'd32, 8'd33);

        do_reset(); set_nominal();
        run_seq("in_change", 1'b1, 8'd12, 8'd10, 8'd9, 8'd10);

        for (int t = 0; t < 5; t++) begin
            do_reset(); set_random();
            run_model("random", 1'b0);
        end

        // Abort mid-run at E6, then restart with the identity tile
        do_reset(); set_nominal();
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst", 64'(outs()), 64'd0);
        set_identity();
        rst = 1'b0;
        run_seq("restart", 1'b0, 8'd22, 8'd23, 8'd32, 8'd33);

        // Reset coinciding with E13 must win
        do_reset(); set_random();
        repeat (12) @(posedge clk);
        #1;
        chk("e12_pre", 64'(outs()), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("e13_rst", 64'(outs()), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("e13_rst_after", 64'(outs()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
